regfile_wb_scheduler: RTL and testbench
=======================================

# regfile_wb_scheduler

Write-back scheduler and scoreboard for the 32×32-bit integer register file. It shares the register file's single write port between two write-back requesters (requester 0: ALU path, requester 1: load path) using round-robin arbitration with a valid/ready handshake. It tracks pending destination registers in a 32-entry busy scoreboard and stalls the issue stage on RAW and WAW hazards. It sits between decode/issue, the execute/load units, and the register file write port.

## Interface
- XLEN, 32, data width of register values
- AW, 5, register address width (32 registers; x0 hardwired zero)

- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_iss_valid  in  1  issue stage presents an instruction
- i_iss_rs1 / i_iss_rs2  in  AW  source register addresses
- i_iss_use_rs1 / i_iss_use_rs2  in  1  instruction reads rs1 / rs2
- i_iss_wr  in  1  instruction writes rd
- i_iss_rd  in  AW  destination register address
- o_iss_ready  out  1  no hazard; issue accepted when i_iss_valid && o_iss_ready
- i_wb0_valid / i_wb1_valid  in  1  write-back request
- i_wb0_rd / i_wb1_rd  in  AW  write-back destination
- i_wb0_data / i_wb1_data  in  XLEN  write-back value
- o_wb0_ready / o_wb1_ready  out  1  grant; request consumed at this edge
- o_rf_wr_addr  out  AW  register file write address
- o_rf_wr_data  out  XLEN  register file write data
- o_rf_wr_wren  out  1  register file write enable
- o_busy  out  32  scoreboard (bit n = xn pending)
- o_pending  out  6  number of busy bits set (0..31)

## Operation
- Scoreboard: on issue handshake with i_iss_wr=1 and i_iss_rd≠0, set busy[rd] at that edge. Clear busy[o_rf_wr_addr] at an edge where o_rf_wr_wren=1. Bit 0 is always 0. If set and clear hit the same bit at the same edge, set wins.
- o_iss_ready = !( (use_rs1 && busy[rs1]) || (use_rs2 && busy[rs2]) || (i_iss_wr && busy[rd]) ). It is combinational from the inputs and the current busy register, and is independent of i_iss_valid.
- Arbiter: a 1-bit priority pointer, reset value 0 (requester 0 preferred).
  - Only one valid: grant it.
  - Both valid: grant the pointer's requester.
  - On any grant, the pointer moves to the other requester.
  - o_wbK_ready is combinational, and at most one is high per cycle.
- Requesters hold valid/rd/data stable until ready. Valid must not drop before ready.
- Output stage is registered. On a grant at edge N, o_rf_wr_addr/data/wren take the granted rd/data during cycle N+1. A granted request with rd=0 is consumed but drives o_rf_wr_wren=0.
- With no grant at an edge, o_rf_wr_wren=0 in the following cycle. addr/data hold their last value.
- o_pending is a registered popcount of the next busy vector. It increments or decrements by at most 1 per edge; simultaneous set and clear of different bits leave it unchanged.

## Timing
- Reset (async assert, immediate): busy=0, o_pending=0, pointer=0, o_rf_wr_wren=0, o_rf_wr_addr=0, o_rf_wr_data=0. o_iss_ready=1, since busy is 0. wb ready follows the inputs.
- Reset mid-operation: in-flight writes and pending entries are discarded. There is no recovery.
- Write-back latency: grant edge N → wren high in cycle N+1 → register file stores at edge N+2 → busy clears at edge N+2. A dependent instruction sees o_iss_ready=1 in the cycle after N+2 and reads the new value from the register file.
- Throughput: one write per cycle. Back-to-back grants from alternating requesters are allowed.
- Issue and write-back on the same cycle are independent.

## Test plan
- Reset: assert i_rst=0 mid-cycle → all outputs listed above at 0 immediately, o_iss_ready=1. Release → issue rs1=3, rd=4 with o_iss_ready=1, busy[4]=1 next cycle, o_pending=1.
- RAW: issue rd=5; issue rs1=5 → o_iss_ready=0. wb0 rd=5, data 0xDEADBEEF granted at edge N → cycle N+1 has addr=5, data=0xDEADBEEF, wren=1. busy[5]=0 and o_iss_ready=1 after edge N+2.
- Arbitration: both wb valid continuously for 4 cycles from reset → grant sequence 0,1,0,1. With only wb1 valid → wb1 granted every cycle.
- x0: issue rd=0 → busy unchanged, o_pending=0. wb1 rd=0, data 0x1234 → wb1_ready=1 and wren stays 0.
- WAW: busy[7]=1, issue rd=7 with no sources → o_iss_ready=0. It rises only after the x7 write-back clears busy[7].
- Reset mid-write: grant wb0 rd=9, then assert reset during cycle N+1 → wren drops to 0 and busy[9]=0 immediately.

Source files
------------

// File: rtl/regfile_wb_scheduler_if.sv
// Write-back scheduler bundle: issue hazard check,
// two write-back requesters and the register file write port.
interface regfile_wb_scheduler_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            i_iss_valid;
  logic [AW-1:0]   i_iss_rs1;
  logic [AW-1:0]   i_iss_rs2;
  logic            i_iss_use_rs1;
  logic            i_iss_use_rs2;
  logic            i_iss_wr;
  logic [AW-1:0]   i_iss_rd;
  logic            o_iss_ready;
  logic            i_wb0_valid;
  logic [AW-1:0]   i_wb0_rd;
  logic [XLEN-1:0] i_wb0_data;
  logic            o_wb0_ready;
  logic            i_wb1_valid;
  logic [AW-1:0]   i_wb1_rd;
  logic [XLEN-1:0] i_wb1_data;
  logic            o_wb1_ready;
  logic [AW-1:0]   o_rf_wr_addr;
  logic [XLEN-1:0] o_rf_wr_data;
  logic            o_rf_wr_wren;
  logic [31:0]     o_busy;
  logic [5:0]      o_pending;

  modport master (
    output i_iss_valid, i_iss_rs1, i_iss_rs2,
    output i_iss_use_rs1, i_iss_use_rs2,
    output i_iss_wr, i_iss_rd,
    output i_wb0_valid, i_wb0_rd, i_wb0_data,
    output i_wb1_valid, i_wb1_rd, i_wb1_data,
    input  o_iss_ready, o_wb0_ready, o_wb1_ready,
    input  o_rf_wr_addr, o_rf_wr_data, o_rf_wr_wren,
    input  o_busy, o_pending
  );

  modport slave (
    input  i_iss_valid, i_iss_rs1, i_iss_rs2,
    input  i_iss_use_rs1, i_iss_use_rs2,
    input  i_iss_wr, i_iss_rd,
    input  i_wb0_valid, i_wb0_rd, i_wb0_data,
    input  i_wb1_valid, i_wb1_rd, i_wb1_data,
    output o_iss_ready, o_wb0_ready, o_wb1_ready,
    output o_rf_wr_addr, o_rf_wr_data, o_rf_wr_wren,
    output o_busy, o_pending
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin write-back arbiter for the single register
// file write port, plus busy scoreboard for RAW/WAW stalls.
module regfile_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input logic i_clk,
  input logic i_rst,
  regfile_wb_scheduler_if.slave bus
);
  localparam int NR = 1 << AW;
  localparam int PW = 6;

  logic [NR-1:0]   busy;
  logic [NR-1:0]   busy_nxt;
  logic [NR-1:0]   set_vec;
  logic [NR-1:0]   clr_vec;
  logic [PW-1:0]   pending;
  logic [PW-1:0]   pend_nxt;
  logic            ptr;
  logic            g0;
  logic            g1;
  logic            hazard;
  logic            iss_fire;
  logic [AW-1:0]   g_rd;
  logic [XLEN-1:0] g_data;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            wren;

  always_comb begin
    g0 = bus.i_wb0_valid &&
         (!bus.i_wb1_valid || !ptr);
    g1 = bus.i_wb1_valid &&
         (!bus.i_wb0_valid || ptr);
    g_rd   = bus.i_wb0_rd;
    g_data = bus.i_wb0_data;
    unique case (1'b1)
      g1:      begin
        g_rd   = bus.i_wb1_rd;
        g_data = bus.i_wb1_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    hazard =
      (bus.i_iss_use_rs1 && busy[bus.i_iss_rs1]) ||
      (bus.i_iss_use_rs2 && busy[bus.i_iss_rs2]) ||
      (bus.i_iss_wr && busy[bus.i_iss_rd]);
    iss_fire = bus.i_iss_valid && !hazard;
    set_vec = '0;
    if (iss_fire && bus.i_iss_wr &&
        bus.i_iss_rd != '0)
      set_vec[bus.i_iss_rd] = 1'b1;
    clr_vec = '0;
    if (wren)
      clr_vec[wr_addr] = 1'b1;
    // set after clear so a same-edge collision keeps the bit
    busy_nxt = (busy & ~clr_vec) | set_vec;
    busy_nxt[0] = 1'b0;
    pend_nxt = '0;
    for (int i = 0; i < NR; i++)
      pend_nxt = pend_nxt + PW'(busy_nxt[i]);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      busy    <= '0;
      pending <= '0;
      ptr     <= 1'b0;
      wren    <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      busy    <= busy_nxt;
      pending <= pend_nxt;
      if (g0 || g1) begin
        ptr     <= g0;
        wr_addr <= g_rd;
        wr_data <= g_data;
        wren    <= (g_rd != '0);
      end else begin
        wren    <= 1'b0;
      end
    end
  end

  assign bus.o_iss_ready  = !hazard;
  assign bus.o_wb0_ready  = g0;
  assign bus.o_wb1_ready  = g1;
  assign bus.o_rf_wr_addr = wr_addr;
  assign bus.o_rf_wr_data = wr_data;
  assign bus.o_rf_wr_wren = wren;
  assign bus.o_busy       = busy;
  assign bus.o_pending    = pending;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scenario tasks plus a randomized run against a
// behavioural scoreboard/arbiter model.
module tb_regfile_wb_scheduler;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  bit          mbusy [32];
  bit          mptr;
  bit          mwren;
  logic [4:0]  maddr;
  logic [31:0] mdata;
  int          last_g;

  regfile_wb_scheduler_if bus ();

  regfile_wb_scheduler dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.i_iss_valid   = 1'b0;
    bus.i_iss_rs1     = '0;
    bus.i_iss_rs2     = '0;
    bus.i_iss_use_rs1 = 1'b0;
    bus.i_iss_use_rs2 = 1'b0;
    bus.i_iss_wr      = 1'b0;
    bus.i_iss_rd      = '0;
    bus.i_wb0_valid   = 1'b0;
    bus.i_wb0_rd      = '0;
    bus.i_wb0_data    = '0;
    bus.i_wb1_valid   = 1'b0;
    bus.i_wb1_rd      = '0;
    bus.i_wb1_data    = '0;
  endtask

  task automatic issue(input bit wr, input int rd,
                       input bit u1, input int rs1);
    bus.i_iss_valid   = 1'b1;
    bus.i_iss_wr      = wr;
    bus.i_iss_rd      = 5'(rd);
    bus.i_iss_use_rs1 = u1;
    bus.i_iss_rs1     = 5'(rs1);
    bus.i_iss_use_rs2 = 1'b0;
    bus.i_iss_rs2     = '0;
  endtask

  function automatic bit exp_iss_ready();
    return !((bus.i_iss_use_rs1 && mbusy[bus.i_iss_rs1]) ||
             (bus.i_iss_use_rs2 && mbusy[bus.i_iss_rs2]) ||
             (bus.i_iss_wr && mbusy[bus.i_iss_rd]));
  endfunction

  function automatic int exp_grant();
    if (bus.i_wb0_valid && bus.i_wb1_valid)
      return int'(mptr);
    if (bus.i_wb0_valid) return 0;
    if (bus.i_wb1_valid) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] mvec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mbusy[i];
    return v;
  endfunction

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    mptr  = 1'b0;
    mwren = 1'b0;
    maddr = '0;
    mdata = '0;
  endtask

  // one clock edge: DUT and model both advance
  task automatic tick();
    int g;
    bit fire;
    g    = exp_grant();
    fire = bus.i_iss_valid && exp_iss_ready();
    @(posedge clk);
    if (mwren) mbusy[maddr] = 1'b0;
    if (fire && bus.i_iss_wr && bus.i_iss_rd != 0)
      mbusy[bus.i_iss_rd] = 1'b1;
    if (g >= 0) begin
      mptr  = (g == 0);
      maddr = (g == 1) ? bus.i_wb1_rd : bus.i_wb0_rd;
      mdata = (g == 1) ? bus.i_wb1_data : bus.i_wb0_data;
      mwren = (maddr != 0);
    end else begin
      mwren = 1'b0;
    end
    last_g = g;
    #1;
  endtask

  task automatic test_reset();
    issue(1'b1, 6, 1'b0, 0);
    tick();
    idle();
    #3 rst = 1'b0;
    model_reset();
    #1;
    n_chk += 6;
    if (bus.o_rf_wr_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wren got %b exp 0", bus.o_rf_wr_wren);
    end
    if (bus.o_rf_wr_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_addr got %0d exp 0", bus.o_rf_wr_addr);
    end
    if (bus.o_rf_wr_data !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_data got %h exp 0", bus.o_rf_wr_data);
    end
    if (bus.o_busy !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_busy got %h exp 0", bus.o_busy);
    end
    if (bus.o_pending !== 6'd0) begin
      n_fail++;
      $display("FAIL rst_pend got %0d exp 0", bus.o_pending);
    end
    if (bus.o_iss_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_issrdy got %b exp 1", bus.o_iss_ready);
    end
    #2 rst = 1'b1;
    tick();
    issue(1'b1, 4, 1'b1, 3);
    #1;
    n_chk++;
    if (bus.o_iss_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_rdy got %b exp 1", bus.o_iss_ready);
    end
    tick();
    idle();
    n_chk += 2;
    if (bus.o_busy[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_busy4 got %b exp 1", bus.o_busy[4]);
    end
    if (bus.o_pending !== 6'd1) begin
      n_fail++;
      $display("FAIL post_rst_pend got %0d exp 1", bus.o_pending);
    end
  endtask

  task automatic test_raw();
    issue(1'b1, 5, 1'b0, 0);
    tick();
    issue(1'b0, 0, 1'b1, 5);
    bus.i_wb0_valid = 1'b1;
    bus.i_wb0_rd    = 5'd5;
    bus.i_wb0_data  = 32'hDEADBEEF;
    #1;
    n_chk += 2;
    if (bus.o_iss_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_stall got %b exp 0", bus.o_iss_ready);
    end
    if (bus.o_wb0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_grant got %b exp 1", bus.o_wb0_ready);
    end
    tick();
    bus.i_wb0_valid = 1'b0;
    #1;
    n_chk += 4;
    if (bus.o_rf_wr_wren !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_wren got %b exp 1", bus.o_rf_wr_wren);
    end
    if (bus.o_rf_wr_addr !== 5'd5) begin
      n_fail++;
      $display("FAIL raw_addr got %0d exp 5", bus.o_rf_wr_addr);
    end
    if (bus.o_rf_wr_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL raw_data got %h exp deadbeef", bus.o_rf_wr_data);
    end
    if (bus.o_iss_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_stall2 got %b exp 0", bus.o_iss_ready);
    end
    tick();
    n_chk += 2;
    if (bus.o_busy[5] !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_clr got %b exp 0", bus.o_busy[5]);
    end
    if (bus.o_iss_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_release got %b exp 1", bus.o_iss_ready);
    end
    tick();
    idle();
  endtask

  task automatic test_arbitration();
    #3 rst = 1'b0;
    model_reset();
    #2 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.i_wb0_valid = 1'b1;
      bus.i_wb0_rd    = 5'(10 + k);
      bus.i_wb0_data  = $urandom;
      bus.i_wb1_valid = 1'b1;
      bus.i_wb1_rd    = 5'(20 + k);
      bus.i_wb1_data  = $urandom;
      #1;
      n_chk += 2;
      if (bus.o_wb0_ready !== (k % 2 == 0)) begin
        n_fail++;
        $display("FAIL arb_rr0[%0d] got %b", k, bus.o_wb0_ready);
      end
      if (bus.o_wb1_ready !== (k % 2 == 1)) begin
        n_fail++;
        $display("FAIL arb_rr1[%0d] got %b", k, bus.o_wb1_ready);
      end
      tick();
      n_chk++;
      if (bus.o_rf_wr_addr !== maddr) begin
        n_fail++;
        $display("FAIL arb_addr[%0d] got %0d exp %0d",
                 k, bus.o_rf_wr_addr, maddr);
      end
    end
    bus.i_wb0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.i_wb1_rd   = 5'(24 + k);
      bus.i_wb1_data = $urandom;
      #1;
      n_chk += 2;
      if (bus.o_wb1_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL arb_only1[%0d] got %b exp 1", k, bus.o_wb1_ready);
      end
      if (bus.o_wb0_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL arb_only0[%0d] got %b exp 0", k, bus.o_wb0_ready);
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_x0();
    issue(1'b1, 0, 1'b0, 0);
    #1;
    n_chk++;
    if (bus.o_iss_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_rdy got %b exp 1", bus.o_iss_ready);
    end
    tick();
    idle();
    n_chk += 2;
    if (bus.o_busy !== 32'd0) begin
      n_fail++;
      $display("FAIL x0_busy got %h exp 0", bus.o_busy);
    end
    if (bus.o_pending !== 6'd0) begin
      n_fail++;
      $display("FAIL x0_pend got %0d exp 0", bus.o_pending);
    end
    bus.i_wb1_valid = 1'b1;
    bus.i_wb1_rd    = 5'd0;
    bus.i_wb1_data  = 32'h1234;
    #1;
    n_chk++;
    if (bus.o_wb1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_wb1rdy got %b exp 1", bus.o_wb1_ready);
    end
    tick();
    idle();
    n_chk++;
    if (bus.o_rf_wr_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_wren got %b exp 0", bus.o_rf_wr_wren);
    end
  endtask

  task automatic test_waw();
    issue(1'b1, 7, 1'b0, 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      n_chk++;
      if (bus.o_iss_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL waw_stall[%0d] got %b exp 0", k, bus.o_iss_ready);
      end
      tick();
    end
    bus.i_wb0_valid = 1'b1;
    bus.i_wb0_rd    = 5'd7;
    bus.i_wb0_data  = 32'h77;
    tick();
    bus.i_wb0_valid = 1'b0;
    #1;
    n_chk++;
    if (bus.o_iss_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL waw_stall_wb got %b exp 0", bus.o_iss_ready);
    end
    tick();
    n_chk++;
    if (bus.o_iss_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL waw_release got %b exp 1", bus.o_iss_ready);
    end
    tick();
    idle();
    n_chk++;
    if (bus.o_busy[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL waw_reissue got %b exp 1", bus.o_busy[7]);
    end
    bus.i_wb1_valid = 1'b1;
    bus.i_wb1_rd    = 5'd7;
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_mid_write();
    issue(1'b1, 9, 1'b0, 0);
    tick();
    idle();
    bus.i_wb0_valid = 1'b1;
    bus.i_wb0_rd    = 5'd9;
    bus.i_wb0_data  = 32'h99;
    tick();
    idle();
    n_chk++;
    if (bus.o_rf_wr_wren !== 1'b1) begin
      n_fail++;
      $display("FAIL rmw_wren1 got %b exp 1", bus.o_rf_wr_wren);
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_chk += 2;
    if (bus.o_rf_wr_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_wren0 got %b exp 0", bus.o_rf_wr_wren);
    end
    if (bus.o_busy[9] !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_busy9 got %b exp 0", bus.o_busy[9]);
    end
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_random();
    bit          rv [2];
    logic [4:0]  rrd [2];
    logic [31:0] rdt [2];
    int          g;
    rv[0] = 0;
    rv[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++)
        if (!rv[r] && $urandom_range(2, 0) != 0) begin
          rv[r]  = 1;
          rrd[r] = 5'($urandom_range(7, 0));
          rdt[r] = $urandom;
        end
      bus.i_wb0_valid   = rv[0];
      bus.i_wb0_rd      = rrd[0];
      bus.i_wb0_data    = rdt[0];
      bus.i_wb1_valid   = rv[1];
      bus.i_wb1_rd      = rrd[1];
      bus.i_wb1_data    = rdt[1];
      bus.i_iss_valid   = 1'($urandom);
      bus.i_iss_wr      = 1'($urandom);
      bus.i_iss_rd      = 5'($urandom_range(7, 0));
      bus.i_iss_use_rs1 = 1'($urandom);
      bus.i_iss_rs1     = 5'($urandom_range(7, 0));
      bus.i_iss_use_rs2 = 1'($urandom);
      bus.i_iss_rs2     = 5'($urandom_range(7, 0));
      #1;
      g = exp_grant();
      n_chk += 3;
      if (bus.o_iss_ready !== exp_iss_ready()) begin
        n_fail++;
        $display("FAIL rnd_iss[%0d] got %b exp %b",
                 c, bus.o_iss_ready, exp_iss_ready());
      end
      if (bus.o_wb0_ready !== (g == 0)) begin
        n_fail++;
        $display("FAIL rnd_g0[%0d] got %b exp %b",
                 c, bus.o_wb0_ready, g == 0);
      end
      if (bus.o_wb1_ready !== (g == 1)) begin
        n_fail++;
        $display("FAIL rnd_g1[%0d] got %b exp %b",
                 c, bus.o_wb1_ready, g == 1);
      end
      tick();
      if (last_g >= 0) rv[last_g] = 0;
      n_chk += 3;
      if (bus.o_rf_wr_wren !== mwren) begin
        n_fail++;
        $display("FAIL rnd_wren[%0d] got %b exp %b",
                 c, bus.o_rf_wr_wren, mwren);
      end
      if (bus.o_busy !== mvec()) begin
        n_fail++;
        $display("FAIL rnd_busy[%0d] got %h exp %h",
                 c, bus.o_busy, mvec());
      end
      if (bus.o_pending !== 6'(mcount())) begin
        n_fail++;
        $display("FAIL rnd_pend[%0d] got %0d exp %0d",
                 c, bus.o_pending, mcount());
      end
      if (mwren) begin
        n_chk += 2;
        if (bus.o_rf_wr_addr !== maddr) begin
          n_fail++;
          $display("FAIL rnd_addr[%0d] got %0d exp %0d",
                   c, bus.o_rf_wr_addr, maddr);
        end
        if (bus.o_rf_wr_data !== mdata) begin
          n_fail++;
          $display("FAIL rnd_data[%0d] got %h exp %h",
                   c, bus.o_rf_wr_data, mdata);
        end
      end
    end
    idle();
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    last_g = -1;
    rst    = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #4 rst = 1'b1;
    tick();
    test_reset();
    test_raw();
    test_arbitration();
    test_x0();
    test_waw();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
